accbuf_reader: RTL and testbench

//  Read-side engine for the per-channel accumulator buffers written by the readout mix/accumulate path.
//  On a start strobe it snapshots each enabled channel's write pointer and reads entries 0..ptr-1 through the BRAM read port.

---
 rtl/accbuf_reader_if.sv | 16 +
 rtl/accbuf_reader.sv | 232 +++++++++++++++++++++++
 tb/tb_accbuf_reader.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accbuf_reader_if.sv
// AXI-stream style output channel of the accumulator-buffer reader.
interface accbuf_reader_if #(
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned NCHAN     = 4
);
  localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [DATAWIDTH-1:0] m_tdata;
  logic [CW-1:0]        m_tuser;
  logic                 m_tlast;
  logic                 m_tvalid;
  logic                 m_tready;

  modport master (output m_tdata, m_tuser, m_tlast, m_tvalid, input m_tready);
  modport slave  (input m_tdata, m_tuser, m_tlast, m_tvalid, output m_tready);
endinterface

// File: rtl/accbuf_reader.sv
// Reads every enabled accumulator buffer (entries 0..ptr-1) after a start strobe
// and streams the words out in channel order through a credit-limited FIFO.
module accbuf_reader #(
  parameter int unsigned NCHAN     = 4,
  parameter int unsigned ADDRWIDTH = 10,
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned RDLAT     = 2,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NCHAN-1:0]              chan_mask,
  input  logic [NCHAN*ADDRWIDTH-1:0]    wr_addr,
  output logic [NCHAN-1:0]              rd_en,
  output logic [ADDRWIDTH-1:0]          rd_addr,
  input  logic [NCHAN*DATAWIDTH-1:0]    rd_data,
  accbuf_reader_if.master               axis,
  output logic                          busy,
  output logic                          done
);
  localparam int unsigned CW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned PW  = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int unsigned FCW = $clog2(FIFODEPTH + 1);
  localparam int unsigned SW  = $clog2(FIFODEPTH + RDLAT + 2) + 1;

  typedef enum logic [1:0] {IDLE, SEL, READ, DRAIN} state_t;
  typedef struct packed { logic valid; logic [CW-1:0] ch; logic last; } pipe_t;
  typedef struct packed { logic [DATAWIDTH-1:0] data; logic [CW-1:0] ch; logic last; } beat_t;

  state_t                             state_q, state_d;
  logic [NCHAN-1:0]                   mask_q, mask_d;
  logic [NCHAN-1:0][ADDRWIDTH-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]                      ch_q, ch_d;
  logic [ADDRWIDTH-1:0]               a_q, a_d;
  logic                               busy_q, busy_d, done_q, done_d;
  logic [NCHAN-1:0]                   rd_en_q, rd_en_d;
  logic [ADDRWIDTH-1:0]               rd_addr_q, rd_addr_d;
  pipe_t                              pipe_q [RDLAT+1];
  pipe_t                              pipe_d [RDLAT+1];
  beat_t [FIFODEPTH-1:0]              mem_q, mem_d;
  logic [PW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]                     fifo_count_q, fifo_count_d;
  beat_t                              out_q, out_d, head_d;
  logic                               tvalid_q, tvalid_d;

  logic [NCHAN-1:0][ADDRWIDTH-1:0]    wr_word;
  logic [NCHAN-1:0][DATAWIDTH-1:0]    rd_word;
  logic                               sel_found, more_work, any_work, credit_ok, drained;
  logic [CW-1:0]                      sel_ch;
  logic [SW-1:0]                      outst;
  logic                               issue, issue_last, flush, push, pop;

  assign wr_word = wr_addr;
  assign rd_word = rd_data;
  assign pop     = tvalid_q & axis.m_tready;
  assign push    = pipe_q[RDLAT].valid;

  // Channel selection, in-flight read count and issue credit.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    more_work = 1'b0;
    any_work  = 1'b0;
    outst     = '0;
    for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
      if (mask_q[i] && cnt_q[i] != '0) begin
        sel_found = 1'b1;
        sel_ch    = CW'(i);
      end
    end
    for (int i = 0; i < int'(NCHAN); i++) begin
      if (mask_q[i] && cnt_q[i] != '0 && CW'(i) != ch_q) more_work = 1'b1;
      if (chan_mask[i] && wr_word[i] != '0) any_work = 1'b1;
    end
    for (int k = 0; k <= int'(RDLAT); k++) begin
      if (pipe_q[k].valid) outst = outst + SW'(1);
    end
    credit_ok = (outst + SW'(fifo_count_q)) < (SW'(FIFODEPTH) + SW'(pop));
    drained   = (outst == '0) &&
                ((fifo_count_q == '0) || (fifo_count_q == FCW'(1) && pop));
  end

  // Transfer FSM: next state, counters and issue decision.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    a_d        = a_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d = chan_mask;
          for (int i = 0; i < int'(NCHAN); i++) cnt_d[i] = chan_mask[i] ? wr_word[i] : '0;
          a_d     = '0;
          busy_d  = 1'b1;
          state_d = any_work ? SEL : DRAIN;
        end
      end
      SEL: begin
        if (sel_found) begin
          ch_d    = sel_ch;
          a_d     = '0;
          state_d = READ;
        end else begin
          state_d = DRAIN;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (a_q == cnt_q[ch_q] - ADDRWIDTH'(1)) begin
            issue_last     = !more_work;
            mask_d[ch_q]   = 1'b0;
            a_d            = '0;
            state_d        = SEL;
          end else begin
            a_d = a_q + ADDRWIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort cancels everything in flight; the cycle after it reports done.
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      busy_d     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      flush      = 1'b0 | 1'b1;
    end
  end

  // BRAM read port, tag pipeline and output FIFO next-state.
  always_comb begin
    rd_en_d   = '0;
    rd_addr_d = rd_addr_q;
    if (issue) begin
      rd_en_d[ch_q] = 1'b1;
      rd_addr_d     = a_q;
    end
    pipe_d[0].valid = issue;
    pipe_d[0].ch    = ch_q;
    pipe_d[0].last  = issue_last;
    for (int k = 1; k <= int'(RDLAT); k++) pipe_d[k] = pipe_q[k-1];
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (flush) begin
      for (int k = 0; k <= int'(RDLAT); k++) pipe_d[k] = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q].data = rd_word[pipe_q[RDLAT].ch];
        mem_d[wr_ptr_q].ch   = pipe_q[RDLAT].ch;
        mem_d[wr_ptr_q].last = pipe_q[RDLAT].last;
        wr_ptr_d = (wr_ptr_q == PW'(FIFODEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == PW'(FIFODEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      fifo_count_d = fifo_count_q + FCW'(push) - FCW'(pop);
    end
    head_d   = mem_d[rd_ptr_d];
    tvalid_d = (fifo_count_d != '0);
    out_d    = tvalid_d ? head_d : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      cnt_q        <= '0;
      ch_q         <= '0;
      a_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= '0;
      rd_addr_q    <= '0;
      for (int k = 0; k <= int'(RDLAT); k++) pipe_q[k] <= '0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      out_q        <= '0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      a_q          <= a_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      for (int k = 0; k <= int'(RDLAT); k++) pipe_q[k] <= pipe_d[k];
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      out_q        <= out_d;
      tvalid_q     <= tvalid_d;
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign axis.m_tvalid = tvalid_q;
  assign axis.m_tdata  = out_q.data;
  assign axis.m_tuser  = out_q.ch;
  assign axis.m_tlast  = out_q.last;
endmodule

// File: tb/tb_accbuf_reader.sv
// Scoreboard bench for accbuf_reader with a behavioural BRAM of fixed read latency.
module tb_accbuf_reader;
  localparam int RDLAT = 2;

  typedef struct packed { logic [63:0] data; logic [1:0] user; logic last; } beat_t;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic [3:0]  chan_mask;
  logic [39:0] wr_addr;
  logic [3:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [255:0] rd_data;
  logic        busy, done;

  accbuf_reader_if #(.DATAWIDTH(64), .NCHAN(4)) axis_if ();

  accbuf_reader #(.NCHAN(4), .ADDRWIDTH(10), .DATAWIDTH(64), .RDLAT(RDLAT), .FIFODEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .chan_mask(chan_mask),
    .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .axis(axis_if), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int stable_err = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    got_cyc[$];
  logic [13:0] rd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: word = {channel, address}, poisoned when not read RDLAT cycles ago.
  logic [3:0] en_pipe [RDLAT];
  logic [9:0] addr_pipe [RDLAT];
  always @(posedge clk) begin
    en_pipe[0]   <= rd_en;
    addr_pipe[0] <= rd_addr;
    for (int i = 1; i < RDLAT; i++) begin
      en_pipe[i]   <= en_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
  end
  always_comb begin
    for (int c = 0; c < 4; c++)
      rd_data[c*64 +: 64] = en_pipe[RDLAT-1][c] ? {32'(c), 22'd0, addr_pipe[RDLAT-1]}
                                                : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Read-port recorder.
  always @(negedge clk) if (rd_en != 4'd0) rd_q.push_back({rd_en, rd_addr});

  task automatic push_exp(input logic [3:0] mask, input logic [39:0] addrs);
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        logic [9:0] n;
        n = addrs[c*10 +: 10];
        for (int a = 0; a < int'(n); a++)
          exp_q.push_back('{data: {32'(c), 32'(a)}, user: 2'(c), last: 1'b0});
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic do_start(input logic [3:0] mask, input logic [39:0] addrs);
    @(negedge clk);
    chan_mask = mask; wr_addr = addrs; start = 1'b1; s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collects accepted beats until done (or the cycle budget runs out).
  // mode 0: ready high; 1: ready toggles; 2: toggles with a 20-cycle low hole.
  task automatic collect(input int max_cyc, input int mode, output int done_cyc);
    logic  stall_p, rdy;
    beat_t prev, cur;
    stall_p = 1'b0; prev = '0;
    got_q.delete(); got_cyc.delete(); done_cyc = -1; stable_err = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      cur = {axis_if.m_tdata, axis_if.m_tuser, axis_if.m_tlast};
      if (stall_p && (!axis_if.m_tvalid || cur !== prev)) stable_err++;
      if (done) begin done_cyc = cyc; break; end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (k % 2 == 0);
        default: rdy = (k % 2 == 0) && !(k >= 30 && k < 50);
      endcase
      axis_if.m_tready = rdy;
      if (axis_if.m_tvalid && rdy) begin got_q.push_back(cur); got_cyc.push_back(cyc); end
      stall_p = axis_if.m_tvalid && !rdy;
      prev = cur;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, rd_addr} !== 16'd0) begin
      errors++; $display("FAIL reset_ctrl got %h expected 0", {busy, done, rd_en, rd_addr});
    end
    checks++;
    if ({axis_if.m_tvalid, axis_if.m_tlast, axis_if.m_tuser, axis_if.m_tdata} !== 68'd0) begin
      errors++; $display("FAIL reset_stream got valid=%b data=%h expected 0", axis_if.m_tvalid, axis_if.m_tdata);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_channel();
    beat_t e, g; int dc, last_c;
    exp_q.delete(); rd_q.delete();
    push_exp(4'b0001, {30'd0, 10'd3});
    do_start(4'b0001, {30'd0, 10'd3});
    collect(200, 0, dc);
    last_c = (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -100;
    checks++;
    if (rd_q.size() != 3 || rd_q[0] !== {4'b0001, 10'd0} || rd_q[1] !== {4'b0001, 10'd1} ||
        rd_q[2] !== {4'b0001, 10'd2}) begin
      errors++; $display("FAIL single_rdaddr got %0d reads expected 3 reads of addr 0,1,2", rd_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL single_beat missing expected %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL single_beat got %h expected %h", g, e); end end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL single_extra got %0d extra beats expected 0", got_q.size()); end
    checks++;
    if (dc != last_c + 1) begin errors++; $display("FAIL single_done_time got %0d expected %0d", dc, last_c + 1); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b expected 0", busy); end
  endtask

  task automatic test_two_channels();
    beat_t e, g; int dc;
    exp_q.delete(); rd_q.delete();
    push_exp(4'b1010, {10'd1, 10'd7, 10'd2, 10'd5});
    do_start(4'b1010, {10'd1, 10'd7, 10'd2, 10'd5});
    wr_addr = {10'd9, 10'd9, 10'd9, 10'd9};
    collect(200, 0, dc);
    checks++;
    if (dc < 0) begin errors++; $display("FAIL two_done_timeout got none expected done"); end
    checks++;
    if (rd_q.size() != 3 || rd_q[0] !== {4'b0010, 10'd0} || rd_q[1] !== {4'b0010, 10'd1} ||
        rd_q[2] !== {4'b1000, 10'd0}) begin
      errors++; $display("FAIL two_rdport got %0d reads expected ch1:0,1 ch3:0", rd_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL two_beat missing expected %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL two_beat got %h expected %h", g, e); end end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL two_extra got %0d extra beats expected 0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    beat_t e, g; int dc, bad;
    exp_q.delete(); bad = 0;
    push_exp(4'b0001, {30'd0, 10'd100});
    do_start(4'b0001, {30'd0, 10'd100});
    collect(1000, 2, dc);
    checks++;
    if (dc < 0) begin errors++; $display("FAIL bp_done_timeout got none expected done"); end
    checks++;
    if (stable_err != 0) begin errors++; $display("FAIL bp_hold_stable got %0d changes expected 0", stable_err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL bp_beat missing expected %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL bp_beat got %h expected %h", g, e); end end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL bp_extra got %0d extra beats expected 0", got_q.size()); end
  endtask

  task automatic test_throughput();
    int dc, span;
    do_start(4'b0001, {30'd0, 10'd100});
    collect(400, 0, dc);
    span = (got_cyc.size() == 100) ? got_cyc[99] - got_cyc[0] : -1;
    checks++;
    if (span != 99) begin errors++; $display("FAIL tput_one_span got %0d expected 99", span); end
    do_start(4'b0011, {20'd0, 10'd10, 10'd10});
    collect(400, 0, dc);
    span = (got_cyc.size() == 20) ? got_cyc[19] - got_cyc[0] : -1;
    checks++;
    if (span != 20) begin errors++; $display("FAIL tput_two_span got %0d expected 20", span); end
  endtask

  task automatic test_empty();
    logic [3:0]  m;
    logic [39:0] ad;
    for (int t = 0; t < 2; t++) begin
      m  = (t == 0) ? 4'b1111 : 4'b0000;
      ad = (t == 0) ? 40'd0 : {10'd4, 10'd4, 10'd4, 10'd4};
      do_start(m, ad);
      checks++;
      if ({done, busy, axis_if.m_tvalid} !== 3'b010) begin
        errors++; $display("FAIL empty_mid%0d got done,busy,valid=%b expected 010", t, {done, busy, axis_if.m_tvalid});
      end
      @(negedge clk);
      checks++;
      if ({done, busy, axis_if.m_tvalid} !== 3'b100 || cyc - s_cyc != 2) begin
        errors++; $display("FAIL empty_done%0d got done,busy,valid=%b at +%0d expected 100 at +2",
                           t, {done, busy, axis_if.m_tvalid}, cyc - s_cyc);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL empty_pulse%0d got %b expected 0", t, done); end
    end
  endtask

  task automatic test_abort();
    beat_t e, g; int n, dc;
    exp_q.delete();
    push_exp(4'b0001, {30'd0, 10'd50});
    do_start(4'b0001, {30'd0, 10'd50});
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      axis_if.m_tready = 1'b1;
      if (axis_if.m_tvalid) begin
        g = {axis_if.m_tdata, axis_if.m_tuser, axis_if.m_tlast};
        e = exp_q.pop_front(); n++; checks++;
        if (g !== e) begin errors++; $display("FAIL abort_pre_beat got %h expected %h", g, e); end
      end
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL abort_pre_count got %0d expected 10", n); end
    @(negedge clk);
    axis_if.m_tready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({axis_if.m_tvalid, done, busy} !== 3'b010) begin
      errors++; $display("FAIL abort_after got valid,done,busy=%b expected 010", {axis_if.m_tvalid, done, busy});
    end
    @(negedge clk);
    checks++;
    if ({axis_if.m_tvalid, done, busy} !== 3'b000) begin
      errors++; $display("FAIL abort_idle got valid,done,busy=%b expected 000", {axis_if.m_tvalid, done, busy});
    end
    exp_q.delete();
    push_exp(4'b0001, {30'd0, 10'd50});
    do_start(4'b0001, {30'd0, 10'd50});
    collect(400, 0, dc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL abort_rerun_beat missing expected %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL abort_rerun_beat got %h expected %h", g, e); end end
    end
    checks++;
    if (got_q.size() != 0 || dc < 0) begin
      errors++; $display("FAIL abort_rerun_end got extra=%0d done_cyc=%0d expected 0 and done", got_q.size(), dc);
    end
  endtask

  task automatic test_start_abort_same();
    int bad;
    bad = 0;
    @(negedge clk);
    chan_mask = 4'b0001; wr_addr = {30'd0, 10'd5}; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; axis_if.m_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || done || axis_if.m_tvalid || rd_en != 4'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL start_abort_same got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_start_while_busy();
    beat_t e, g; int dc, bad;
    exp_q.delete(); bad = 0;
    axis_if.m_tready = 1'b0;
    push_exp(4'b0001, {30'd0, 10'd5});
    do_start(4'b0001, {30'd0, 10'd5});
    repeat (3) @(negedge clk);
    chan_mask = 4'b0010; wr_addr = {20'd0, 10'd7, 10'd0}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(200, 0, dc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL busy_start_beat missing expected %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL busy_start_beat got %h expected %h", g, e); end end
    end
    checks++;
    if (got_q.size() != 0 || dc < 0) begin
      errors++; $display("FAIL busy_start_end got extra=%0d done_cyc=%0d expected 0 and done", got_q.size(), dc);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || axis_if.m_tvalid) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_start_ignored got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_async_reset();
    beat_t e, g; int dc;
    do_start(4'b0001, {30'd0, 10'd20});
    collect(8, 0, dc);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, axis_if.m_tvalid, axis_if.m_tlast, axis_if.m_tdata} !== 71'd0) begin
      errors++; $display("FAIL async_reset got busy=%b rd_en=%b valid=%b expected all 0", busy, rd_en, axis_if.m_tvalid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL async_reset_done got %b expected 0", done); end
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    push_exp(4'b0100, {10'd0, 10'd4, 20'd0});
    do_start(4'b0100, {10'd0, 10'd4, 20'd0});
    collect(200, 0, dc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL post_reset_beat missing expected %h", e); end
      else begin g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL post_reset_beat got %h expected %h", g, e); end end
    end
    checks++;
    if (got_q.size() != 0 || dc < 0) begin
      errors++; $display("FAIL post_reset_end got extra=%0d done_cyc=%0d expected 0 and done", got_q.size(), dc);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; chan_mask = '0; wr_addr = '0;
    axis_if.m_tready = 1'b0;
    test_reset();
    test_single_channel();
    test_two_channels();
    test_backpressure();
    test_throughput();
    test_empty();
    test_abort();
    test_start_abort_same();
    test_start_while_busy();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
